sys_array_host_ctrl: RTL
========================

Name: sys_array_host_ctrl

Overview:
- Host-side sequencer that drives the systolic-array fetcher.
- Receives a byte stream carrying the weight matrix and the data matrix, and assembles both into flat operand registers.
- Pulses load_params, then start_comp, then waits for the result.
- Captures the result matrix and streams it back out byte by byte over a valid/ready interface. It is the initiator/consumer end of the fetcher's load/start/ready interface.

Parameters:
- DATA_WIDTH, 8, element width; also the width of the in/out stream beats.
- ARRAY_W_W, 2, weight rows.
- ARRAY_W_L, 5, weight columns; must equal ARRAY_A_W.
- ARRAY_A_W, 5, data rows.
- ARRAY_A_L, 2, data columns.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_data  in  DATA_WIDTH  input element
- in_ready  out  1  block accepts beat
- load_params  out  1  one-cycle weight-load strobe to fetcher
- start_comp  out  1  one-cycle compute-start strobe to fetcher
- data_w  out  ARRAY_W_W*ARRAY_W_L*DATA_WIDTH  weight matrix, element [0][0] in MSBs, row-major
- data_b  out  ARRAY_A_W*ARRAY_A_L*DATA_WIDTH  data matrix, same packing
- fetch_ready  in  1  fetcher ready (level, sticky once set)
- fetch_result  in  ARRAY_W_W*ARRAY_A_L*2*DATA_WIDTH  result matrix, same packing
- out_valid  out  1  output beat valid
- out_data  out  DATA_WIDTH  output byte
- out_ready  in  1  downstream accepts beat
- busy  out  1  high in every state except S_RECV_W with zero elements received

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, reset_n. Reset is sampled every cycle and overrides every state, including mid-operation.
- Reset values: all outputs 0; data_w, data_b and the result register are cleared; FSM goes to S_RECV_W; element counter is 0.
- Localparams:
  - NW = ARRAY_W_W*ARRAY_W_L
  - NB = ARRAY_A_W*ARRAY_A_L
  - NR = ARRAY_W_W*ARRAY_A_L
  - LAT = ARRAY_A_L+ARRAY_A_W+ARRAY_W_W+4
- S_RECV_W:
  - in_ready=1.
  - Each in_valid&in_ready beat stores in_data into weight element idx (row-major) and increments idx.
  - On the beat where idx==NW-1: reset idx to 0 and go to S_LOAD.
- S_LOAD:
  - in_ready=0.
  - load_params=1 for exactly this one cycle; data_w is already stable.
  - Next state is S_RECV_B.
- S_RECV_B:
  - Same as S_RECV_W, but fills data_b.
  - On the beat where idx==NB-1 go to S_START.
- S_START:
  - start_comp=1 for one cycle.
  - Wait counter loads LAT.
  - Next state is S_WAIT.
- S_WAIT:
  - Counter decrements each cycle.
  - When counter==0 AND fetch_ready==1, go to S_CAPTURE.
  - fetch_ready alone is not sufficient, because it is sticky across runs.
- S_CAPTURE:
  - Register fetch_result in one cycle.
  - Byte index = 0.
  - Next state is S_SEND.
- S_SEND:
  - Send NR elements, 2*NR beats in total.
  - Each element is sent high byte first, then low byte; elements go in row-major order.
  - out_valid=1 and out_data is held stable until out_ready.
  - On the handshake of the last beat, out_valid drops the next cycle and the FSM returns to S_RECV_W.
- Interface rules:
  - in_valid is ignored when in_ready=0; no beat is lost or double-counted.
  - in_ready and out_valid are never high in the same cycle.
  - load_params and start_comp are never high in the same cycle.
  - Back-to-back runs are allowed: the next weight stream may start the cycle after the final output handshake.
  - Weights are resent every run.
- Reset mid-operation (including in S_WAIT or S_SEND): outputs clear on the next edge; any partial output stream is abandoned with no further beats.
- Widths: DATA_WIDTH is limited to 8 so that one element equals one beat. Results are 2*DATA_WIDTH wide and are passed through unmodified.

Optional Feature:
- Macro: SYS_ARRAY_HOST_CTRL_CSUM_EN.
- Defined:
  - After the last result byte, one extra beat is sent in S_SEND: the XOR of all 2*NR result bytes.
  - Total beats = 2*NR+1.
  - The checksum is computed incrementally at capture/send and does not stall the stream.
- Undefined: exactly 2*NR beats; no checksum logic is present.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> all outputs 0, in_ready=0; in_ready=1 one cycle after release.
- Weight load: stream W = 1,2,3,4,5,1,1,1,1,1 -> data_w = 0x01020304050101010101; load_params high exactly 1 cycle after the 10th beat; in_ready low during that cycle.
- Full run:
  - Stimulus: stream B = 1,0,0,1,1,0,0,1,1,0, then a fetcher model returns result {0x0009,0x0006,0x0003,0x0002} with fetch_ready=1 after LAT.
  - Response: start_comp pulses 1 cycle after the last B beat; out bytes are 00,09,00,06,00,03,00,02 (with CSUM_EN, a 9th byte 0x0E).
- Backpressure: toggle out_ready 1/0 each cycle -> no byte duplicated or dropped, out_data stable while out_valid&!out_ready.
- Sticky ready: second run with fetch_ready held 1 from the first run -> capture occurs no earlier than LAT cycles after start_comp.
- Mid-run reset: assert reset_n=0 on the 3rd output beat -> out_valid=0 next cycle, FSM idle, a new run completes correctly.

Source files
------------

// File: rtl/sys_array_host_ctrl.sv
// Host-side sequencer for the systolic-array fetcher: assembles weight/data operands from a byte
// stream, strobes load/start, captures the result and streams it out. Macro: SYS_ARRAY_HOST_CTRL_CSUM_EN.
module sys_array_host_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 2,
  parameter int ARRAY_W_L  = 5,
  parameter int ARRAY_A_W  = 5,
  parameter int ARRAY_A_L  = 2
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        in_valid,
  input  logic [DATA_WIDTH-1:0]                       in_data,
  output logic                                        in_ready,
  output logic                                        load_params,
  output logic                                        start_comp,
  output logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]   data_w,
  output logic [ARRAY_A_W*ARRAY_A_L*DATA_WIDTH-1:0]   data_b,
  input  logic                                        fetch_ready,
  input  logic [ARRAY_W_W*ARRAY_A_L*2*DATA_WIDTH-1:0] fetch_result,
  output logic                                        out_valid,
  output logic [DATA_WIDTH-1:0]                       out_data,
  input  logic                                        out_ready,
  output logic                                        busy
);

  localparam int NW     = ARRAY_W_W * ARRAY_W_L;
  localparam int NB     = ARRAY_A_W * ARRAY_A_L;
  localparam int NR     = ARRAY_W_W * ARRAY_A_L;
  localparam int LAT    = ARRAY_A_L + ARRAY_A_W + ARRAY_W_W + 4;
  localparam int WW     = NW * DATA_WIDTH;
  localparam int BWD    = NB * DATA_WIDTH;
  localparam int RW     = NR * 2 * DATA_WIDTH;
`ifdef SYS_ARRAY_HOST_CTRL_CSUM_EN
  localparam int NBEATS = 2 * NR + 1;
`else
  localparam int NBEATS = 2 * NR;
`endif
  localparam int NMAX   = (NW > NB) ? NW : NB;
  localparam int IDX_W  = $clog2(NMAX + 1);
  localparam int WAIT_W = $clog2(LAT + 1);
  localparam int BEAT_W = $clog2(NBEATS + 1);

  typedef enum logic [2:0] {
    S_RECV_W  = 3'd0,
    S_LOAD    = 3'd1,
    S_RECV_B  = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_CAPTURE = 3'd5,
    S_SEND    = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [WW-1:0]         data_w_q, data_w_d;
  logic [BWD-1:0]        data_b_q, data_b_d;
  logic [RW-1:0]         result_q, result_d;
  logic                  in_ready_q, in_ready_d;
  logic                  load_params_q, load_params_d;
  logic                  start_comp_q, start_comp_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  busy_q, busy_d;
`ifdef SYS_ARRAY_HOST_CTRL_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  // Result bytes are numbered MSB-first, so byte k is element k/2, high byte on even k.
  function automatic logic [DATA_WIDTH-1:0] result_byte(input logic [RW-1:0] r,
                                                        input logic [BEAT_W-1:0] k);
    if (int'(k) < 2 * NR) begin
      result_byte = r[(2 * NR - 1 - int'(k)) * DATA_WIDTH +: DATA_WIDTH];
    end else begin
      result_byte = '0;
    end
  endfunction

  // State register and all registered outputs; reset overrides every state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_RECV_W;
      idx_q         <= '0;
      wait_q        <= '0;
      beat_q        <= '0;
      data_w_q      <= '0;
      data_b_q      <= '0;
      result_q      <= '0;
      in_ready_q    <= 1'b0;
      load_params_q <= 1'b0;
      start_comp_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
`ifdef SYS_ARRAY_HOST_CTRL_CSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      beat_q        <= beat_d;
      data_w_q      <= data_w_d;
      data_b_q      <= data_b_d;
      result_q      <= result_d;
      in_ready_q    <= in_ready_d;
      load_params_q <= load_params_d;
      start_comp_q  <= start_comp_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      busy_q        <= busy_d;
`ifdef SYS_ARRAY_HOST_CTRL_CSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    beat_d   = beat_q;
    data_w_d = data_w_q;
    data_b_d = data_b_q;
    result_d = result_q;
`ifdef SYS_ARRAY_HOST_CTRL_CSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_RECV_W: begin
        if (in_valid && in_ready_q) begin
          data_w_d[(NW - 1 - int'(idx_q)) * DATA_WIDTH +: DATA_WIDTH] = in_data;
          if (idx_q == IDX_W'(NW - 1)) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_LOAD: begin
        state_d = S_RECV_B;
      end
      S_RECV_B: begin
        if (in_valid && in_ready_q) begin
          data_b_d[(NB - 1 - int'(idx_q)) * DATA_WIDTH +: DATA_WIDTH] = in_data;
          if (idx_q == IDX_W'(NB - 1)) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_START: begin
        wait_d  = WAIT_W'(LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // fetch_ready stays high from the previous run, so the counter must expire too.
        if (wait_q == '0) begin
          if (fetch_ready) begin
            state_d = S_CAPTURE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_CAPTURE: begin
        result_d = fetch_result;
        beat_d   = '0;
`ifdef SYS_ARRAY_HOST_CTRL_CSUM_EN
        csum_d   = '0;
`endif
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
`ifdef SYS_ARRAY_HOST_CTRL_CSUM_EN
          if (int'(beat_q) < 2 * NR) begin
            csum_d = csum_q ^ out_data_q;
          end else begin
            csum_d = csum_q;
          end
`endif
          if (beat_q == BEAT_W'(NBEATS - 1)) begin
            beat_d  = '0;
            state_d = S_RECV_W;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = S_RECV_W;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop aligned with state_q.
  always_comb begin
    in_ready_d    = (state_d == S_RECV_W) || (state_d == S_RECV_B);
    load_params_d = (state_d == S_LOAD);
    start_comp_d  = (state_d == S_START);
    out_valid_d   = (state_d == S_SEND);
    busy_d        = !((state_d == S_RECV_W) && (idx_d == '0));
    if (state_d == S_SEND) begin
`ifdef SYS_ARRAY_HOST_CTRL_CSUM_EN
      if (int'(beat_d) == 2 * NR) begin
        out_data_d = csum_d;
      end else begin
        out_data_d = result_byte(result_d, beat_d);
      end
`else
      out_data_d = result_byte(result_d, beat_d);
`endif
    end else begin
      out_data_d = '0;
    end
  end

  assign in_ready    = in_ready_q;
  assign load_params = load_params_q;
  assign start_comp  = start_comp_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign data_w      = data_w_q;
  assign data_b      = data_b_q;

endmodule
